ysyx_25060170_seq_ctrl: RTL and testbench
=========================================

YSYX_25060170_SEQ_CTRL -- requirements
Module: ysyx_25060170_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for any fetch or memory response.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port ifu_req_valid, output, 1, fetch request to IFU.
REQ-005 SHALL have port ifu_req_ready, input, 1, IFU accepts request.
REQ-006 SHALL have port ifu_rsp_valid, input, 1, fetched instruction available.
REQ-007 SHALL have port ifu_rsp_inst, input, 32, fetched instruction.
REQ-008 SHALL have port inst_o, output, 32, latched instruction driven to IDU.
REQ-009 SHALL have port idu_regw, input, 1, IDU register-write decode.
REQ-010 SHALL have port lsu_req_valid, output, 1, load/store request to LSU.
REQ-011 SHALL have port lsu_req_ready, input, 1, LSU accepts request.
REQ-012 SHALL have port lsu_rsp_valid, input, 1, LSU access complete.
REQ-013 SHALL have port gpr_we, output, 1, GPR write strobe.
REQ-014 SHALL have port pc_we, output, 1, PC update strobe.
REQ-015 SHALL have port halt_o, output, 1, ebreak reached; err_o, output, 1, illegal opcode or timeout; state_o, output, 4, current state code.

Function
REQ-016 SHALL implement states FETCH(0), FWAIT(1), DECODE(2), EXEC(3), MEM(4), MWAIT(5), WB(6), HALT(7), ERR(8).
REQ-017 SHALL assert ifu_req_valid only in FETCH; FETCH->FWAIT when ifu_req_ready=1 in the same cycle, else hold.
REQ-018 SHALL, in FWAIT, latch ifu_rsp_inst into inst_o and go to DECODE on ifu_rsp_valid=1; inst_o holds otherwise.
REQ-019 SHALL, in DECODE, go to HALT if inst_o==32'h00100073, to ERR if opcode not in {0110011,0010011,0010111,0000011,0100011,1100111,1101111}, else to EXEC.
REQ-020 SHALL spend exactly one cycle in EXEC; next is MEM for opcode 0000011/0100011, else WB.
REQ-021 SHALL assert lsu_req_valid only in MEM; MEM->MWAIT on lsu_req_ready=1; MWAIT->WB on lsu_rsp_valid=1.
REQ-022 SHALL, in WB (one cycle), assert pc_we=1 and gpr_we=idu_regw, then return to FETCH; gpr_we/pc_we SHALL be 0 in every other state.
REQ-023 SHALL keep an 8-bit (clog2(TIMEOUT+1)) wait counter, cleared on entering FETCH/FWAIT/MEM/MWAIT and incremented each cycle spent in those states; reaching TIMEOUT without the awaited handshake SHALL move to ERR.
REQ-024 SHALL give the handshake priority over timeout when both occur in the same cycle.
REQ-025 SHALL treat HALT and ERR as absorbing until reset; halt_o=1 only in HALT, err_o=1 only in ERR.
REQ-026 SHALL ignore ifu_rsp_valid outside FWAIT and lsu_rsp_valid outside MWAIT.
REQ-027 SHALL drive all outputs from registered state (Moore); no combinational input-to-output path.
REQ-028 SHALL complete a non-memory instruction in 5 cycles and a memory instruction in 7 cycles with zero-wait handshakes.

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge, set state=FETCH, inst_o=32'h00000013 (nop), counter=0; outputs follow: ifu_req_valid=1, others 0.
REQ-030 SHALL abandon any in-flight fetch or LSU transaction when reset is applied mid-operation; no WB strobe is produced.

Structure
REQ-031 SHALL place state encodings, opcode constants and the ebreak constant in shared package ysyx_25060170_pkg.
REQ-032 SHALL be a single module; the timeout counter MAY be sub-module ysyx_25060170_wait_cnt.

Verification
REQ-033 SHALL test addi 32'h00500093, all handshakes same-cycle -> FETCH,FWAIT,DECODE,EXEC,WB; gpr_we=1, pc_we=1 in cycle 5.
REQ-034 SHALL test lw 32'h0000a103, lsu_rsp_valid delayed 3 cycles -> MWAIT held 3 cycles, then single WB with gpr_we=1.
REQ-035 SHALL test sw 32'h0020a023 with idu_regw=0 -> MEM/MWAIT visited, WB has pc_we=1, gpr_we=0.
REQ-036 SHALL test ebreak 32'h00100073 -> HALT after DECODE, halt_o=1 stays, no further ifu_req_valid.
REQ-037 SHALL test opcode 7'b0110111 -> ERR; and ifu_rsp_valid held 0 for TIMEOUT cycles -> ERR, err_o=1.
REQ-038 SHALL test rst_n=0 asserted in MWAIT -> next cycle state_o=0, inst_o=32'h00000013, no gpr_we pulse.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// rtl/ysyx_25060170_pkg.sv - state codes, opcode classes and fixed instruction words
package ysyx_25060170_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_FWAIT  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC   = 4'd3;
  localparam logic [3:0] ST_MEM    = 4'd4;
  localparam logic [3:0] ST_MWAIT  = 4'd5;
  localparam logic [3:0] ST_WB     = 4'd6;
  localparam logic [3:0] ST_HALT   = 4'd7;
  localparam logic [3:0] ST_ERR    = 4'd8;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_NOP    = 32'h00000013;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_REG, OP_IMM, OP_AUIPC, OP_LOAD, OP_STORE, OP_JALR, OP_JAL: is_legal_op = 1'b1;
      default:                                                      is_legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    is_mem_op = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/ysyx_25060170_wait_cnt.sv
// rtl/ysyx_25060170_wait_cnt.sv - handshake wait counter, cleared on state entry
module ysyx_25060170_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_25060170_seq_ctrl.sv
// rtl/ysyx_25060170_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer
module ysyx_25060170_seq_ctrl
  import ysyx_25060170_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] inst_o,
  input  logic        idu_regw,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        gpr_we,
  output logic        pc_we,
  output logic        halt_o,
  output logic        err_o,
  output logic [3:0]  state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [31:0]   r_inst;
  logic          r_gpr_we;
  logic          r_pc_we;
  logic [CW-1:0] w_cnt;
  logic          w_wait;
  logic          w_expired;
  logic [6:0]    w_op;

  assign w_op      = r_inst[6:0];
  assign w_wait    = (r_state == ST_FETCH) || (r_state == ST_FWAIT) ||
                     (r_state == ST_MEM)   || (r_state == ST_MWAIT);
  assign w_expired = (w_cnt == TO_LAST);

  // Handshake is tested before the timeout so a last-cycle response still wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (ifu_req_ready) w_next = ST_FWAIT;  else if (w_expired) w_next = ST_ERR;
      ST_FWAIT:  if (ifu_rsp_valid) w_next = ST_DECODE; else if (w_expired) w_next = ST_ERR;
      ST_DECODE: begin
        if (r_inst == INST_EBREAK)  w_next = ST_HALT;
        else if (!is_legal_op(w_op)) w_next = ST_ERR;
        else                         w_next = ST_EXEC;
      end
      ST_EXEC:   w_next = is_mem_op(w_op) ? ST_MEM : ST_WB;
      ST_MEM:    if (lsu_req_ready) w_next = ST_MWAIT; else if (w_expired) w_next = ST_ERR;
      ST_MWAIT:  if (lsu_rsp_valid) w_next = ST_WB;    else if (w_expired) w_next = ST_ERR;
      ST_WB:     w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      ST_ERR:    w_next = ST_ERR;
      default:   w_next = ST_ERR;
    endcase
  end

  ysyx_25060170_wait_cnt #(
    .W (CW)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_next != r_state),
    .i_inc (w_wait),
    .o_cnt (w_cnt)
  );

  // Write strobes are registered on WB entry so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_inst   <= INST_NOP;
      r_gpr_we <= 1'b0;
      r_pc_we  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_gpr_we <= (w_next == ST_WB) && idu_regw;
      r_pc_we  <= (w_next == ST_WB);
      if ((r_state == ST_FWAIT) && ifu_rsp_valid) begin
        r_inst <= ifu_rsp_inst;
      end
    end
  end

  assign ifu_req_valid = (r_state == ST_FETCH);
  assign lsu_req_valid = (r_state == ST_MEM);
  assign halt_o        = (r_state == ST_HALT);
  assign err_o         = (r_state == ST_ERR);
  assign gpr_we        = r_gpr_we;
  assign pc_we         = r_pc_we;
  assign inst_o        = r_inst;
  assign state_o       = r_state;

endmodule

// File: tb/tb_ysyx_25060170_seq_ctrl.sv
// tb/tb_ysyx_25060170_seq_ctrl.sv - scoreboard bench for the sequencer
module tb_ysyx_25060170_seq_ctrl;
  import ysyx_25060170_pkg::*;

  localparam int TO = 255;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000a103;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_ADD  = 32'h002081b3;
  localparam logic [31:0] I_LUI  = 32'h000000b7;
  localparam logic [31:0] I_JUNK = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst, inst_o;
  logic        idu_regw, lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        gpr_we, pc_we, halt_o, err_o;
  logic [3:0]  state_o;

  ysyx_25060170_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .inst_o        (inst_o),
    .idu_regw      (idu_regw),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .gpr_we        (gpr_we),
    .pc_we         (pc_we),
    .halt_o        (halt_o),
    .err_o         (err_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        gw;
    logic        pw;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_trace  = 0;

  // Monitor: every expected cycle record is compared against the DUT outputs mid-cycle.
  initial begin
    exp_t        e;
    logic [41:0] want, got;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        want = {e.st, e.gw, e.pw, e.st == ST_FETCH, e.st == ST_MEM,
                e.st == ST_HALT, e.st == ST_ERR, e.inst};
        got  = {state_o, gpr_we, pc_we, ifu_req_valid, lsu_req_valid,
                halt_o, err_o, inst_o};
        n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL trace[%0d]: got st=%0d gw=%b pw=%b ifv=%b lsv=%b h=%b e=%b inst=%h, want st=%0d gw=%b pw=%b ifv=%b lsv=%b h=%b e=%b inst=%h",
                   n_trace, got[41:38], got[37], got[36], got[35], got[34], got[33], got[32], got[31:0],
                   want[41:38], want[37], want[36], want[35], want[34], want[33], want[32], want[31:0]);
        end
        n_trace++;
      end
    end
  end

  task automatic tick(input logic [3:0] es, input logic egw, input logic epw, input logic [31:0] einst);
    exp_q.push_back('{st: es, gw: egw, pw: epw, inst: einst});
    @(negedge clk);
  endtask

  task automatic drv(input logic rdy, input logic rv, input logic [31:0] ri,
                     input logic lrdy, input logic lrv);
    ifu_req_ready = rdy;
    ifu_rsp_valid = rv;
    ifu_rsp_inst  = ri;
    lsu_req_ready = lrdy;
    lsu_rsp_valid = lrv;
  endtask

  initial begin
    rst_n = 1'b0;
    idu_regw = 1'b0;
    drv(1'b1, 1'b1, I_JUNK, 1'b1, 1'b1);
    @(negedge clk);
    tick(ST_FETCH, 0, 0, INST_NOP);
    tick(ST_FETCH, 0, 0, INST_NOP);
    rst_n = 1'b1;

    // addi, all handshakes immediate; rsp_valid during FETCH is ignored
    idu_regw = 1'b1;
    drv(1, 1, I_ADDI, 0, 0);
    tick(ST_FETCH, 0, 0, INST_NOP);
    tick(ST_FWAIT, 0, 0, INST_NOP);
    drv(1, 1, I_JUNK, 1, 1);
    tick(ST_DECODE, 0, 0, I_ADDI);
    tick(ST_EXEC, 0, 0, I_ADDI);
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_WB, 1, 1, I_ADDI);

    // lw with FETCH stall, MEM stall, MWAIT held 3 cycles
    tick(ST_FETCH, 0, 0, I_ADDI);
    drv(1, 0, I_LW, 0, 0);
    tick(ST_FETCH, 0, 0, I_ADDI);
    drv(0, 1, I_LW, 0, 0);
    tick(ST_FWAIT, 0, 0, I_ADDI);
    drv(0, 1, I_JUNK, 0, 1);
    tick(ST_DECODE, 0, 0, I_LW);
    tick(ST_EXEC, 0, 0, I_LW);
    tick(ST_MEM, 0, 0, I_LW);
    drv(0, 0, I_JUNK, 1, 0);
    tick(ST_MEM, 0, 0, I_LW);
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_MWAIT, 0, 0, I_LW);
    tick(ST_MWAIT, 0, 0, I_LW);
    drv(0, 0, I_JUNK, 0, 1);
    tick(ST_MWAIT, 0, 0, I_LW);
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_WB, 1, 1, I_LW);

    // sw with idu_regw=0
    idu_regw = 1'b0;
    drv(1, 1, I_SW, 0, 0);
    tick(ST_FETCH, 0, 0, I_LW);
    tick(ST_FWAIT, 0, 0, I_LW);
    drv(0, 0, I_JUNK, 1, 1);
    tick(ST_DECODE, 0, 0, I_SW);
    tick(ST_EXEC, 0, 0, I_SW);
    tick(ST_MEM, 0, 0, I_SW);
    tick(ST_MWAIT, 0, 0, I_SW);
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_WB, 0, 1, I_SW);

    // add: response arrives on the very last allowed FWAIT cycle
    idu_regw = 1'b1;
    drv(1, 0, I_ADD, 0, 0);
    tick(ST_FETCH, 0, 0, I_SW);
    for (int i = 0; i < TO; i++) tick(ST_FWAIT, 0, 0, I_SW);
    drv(0, 1, I_ADD, 0, 0);
    tick(ST_FWAIT, 0, 0, I_SW);
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_DECODE, 0, 0, I_ADD);
    tick(ST_EXEC, 0, 0, I_ADD);
    tick(ST_WB, 1, 1, I_ADD);

    // lui is not a supported opcode -> ERR, absorbing
    drv(1, 1, I_LUI, 0, 0);
    tick(ST_FETCH, 0, 0, I_ADD);
    tick(ST_FWAIT, 0, 0, I_ADD);
    drv(1, 1, I_ADDI, 1, 1);
    tick(ST_DECODE, 0, 0, I_LUI);
    tick(ST_ERR, 0, 0, I_LUI);
    tick(ST_ERR, 0, 0, I_LUI);
    rst_n = 1'b0;
    tick(ST_ERR, 0, 0, I_LUI);
    rst_n = 1'b1;

    // ebreak -> HALT, absorbing, no fetch request
    drv(1, 1, INST_EBREAK, 0, 0);
    tick(ST_FETCH, 0, 0, INST_NOP);
    tick(ST_FWAIT, 0, 0, INST_NOP);
    drv(1, 1, I_ADDI, 1, 1);
    tick(ST_DECODE, 0, 0, INST_EBREAK);
    tick(ST_HALT, 0, 0, INST_EBREAK);
    tick(ST_HALT, 0, 0, INST_EBREAK);
    tick(ST_HALT, 0, 0, INST_EBREAK);
    rst_n = 1'b0;
    tick(ST_HALT, 0, 0, INST_EBREAK);
    rst_n = 1'b1;

    // fetch response never arrives -> ERR after TIMEOUT+1 FWAIT cycles
    drv(1, 0, I_ADDI, 0, 0);
    tick(ST_FETCH, 0, 0, INST_NOP);
    for (int i = 0; i <= TO; i++) tick(ST_FWAIT, 0, 0, INST_NOP);
    tick(ST_ERR, 0, 0, INST_NOP);
    tick(ST_ERR, 0, 0, INST_NOP);
    rst_n = 1'b0;
    tick(ST_ERR, 0, 0, INST_NOP);
    rst_n = 1'b1;

    // reset while in MWAIT: no WB strobe, back to FETCH with nop
    drv(1, 1, I_LW, 0, 0);
    tick(ST_FETCH, 0, 0, INST_NOP);
    tick(ST_FWAIT, 0, 0, INST_NOP);
    drv(0, 0, I_JUNK, 1, 0);
    tick(ST_DECODE, 0, 0, I_LW);
    tick(ST_EXEC, 0, 0, I_LW);
    tick(ST_MEM, 0, 0, I_LW);
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_MWAIT, 0, 0, I_LW);
    rst_n = 1'b0;
    lsu_rsp_valid = 1'b1;
    tick(ST_MWAIT, 0, 0, I_LW);
    rst_n = 1'b1;
    drv(0, 0, I_JUNK, 0, 0);
    tick(ST_FETCH, 0, 0, INST_NOP);
    tick(ST_FETCH, 0, 0, INST_NOP);

    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
